// File: rtl/uart_rx_frame_timer.sv
// UART RX oversampling timer: per-bit edge counter, per-frame bit counter,
// 3-sample majority vote and bit/frame boundary pulses.
module uart_rx_frame_timer #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cnt_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BIT_CNT_W-1:0]  frame_len,
  input  logic                  rx_in,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  bit_valid,
  output logic                  sampled_bit,
  output logic                  bit_done,
  output logic                  frame_done,
  output logic                  active
);

  localparam logic [PRESCALE_W-1:0] P_ONE = 1;
  localparam logic [PRESCALE_W-1:0] P_MIN = 4;
  localparam logic [BIT_CNT_W-1:0]  L_ONE = 1;
  localparam logic [BIT_CNT_W-1:0]  L_MIN = 2;

  logic [PRESCALE_W-1:0] p_sh;
  logic [BIT_CNT_W-1:0]  l_sh;
  logic                  s0;
  logic                  s1;

  logic [PRESCALE_W-1:0] p_live;
  logic [PRESCALE_W-1:0] p_use;
  logic [PRESCALE_W-1:0] c_use;
  logic [BIT_CNT_W-1:0]  l_live;
  logic [BIT_CNT_W-1:0]  l_use;
  logic                  wrap_e;
  logic                  last_b;
  logic                  maj;

  // The capturing edge itself runs on the live (clamped) values.
  assign p_live = (prescale < P_MIN) ? P_MIN : prescale;
  assign l_live = (frame_len < L_MIN) ? L_MIN : frame_len;
  assign p_use  = active ? p_sh : p_live;
  assign l_use  = active ? l_sh : l_live;
  assign c_use  = p_use >> 1;
  assign wrap_e = (edge_cnt == p_use - P_ONE);
  assign last_b = (bit_cnt == l_use - L_ONE);
  assign maj    = (s0 & s1) | (s0 & rx_in) | (s1 & rx_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_sh        <= '0;
      l_sh        <= '0;
      s0          <= 1'b0;
      s1          <= 1'b0;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      bit_valid   <= 1'b0;
      sampled_bit <= 1'b0;
      bit_done    <= 1'b0;
      frame_done  <= 1'b0;
      active      <= 1'b0;
    end else if (!cnt_en) begin
      s0         <= 1'b0;
      s1         <= 1'b0;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      bit_valid  <= 1'b0;
      bit_done   <= 1'b0;
      frame_done <= 1'b0;
      active     <= 1'b0;
    end else begin
      active     <= 1'b1;
      bit_valid  <= 1'b0;
      bit_done   <= 1'b0;
      frame_done <= 1'b0;
      if (!active) begin
        p_sh <= p_live;
        l_sh <= l_live;
      end
      if (wrap_e) begin
        edge_cnt <= '0;
        bit_done <= 1'b1;
        if (last_b) begin
          bit_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + L_ONE;
        end
      end else begin
        edge_cnt <= edge_cnt + P_ONE;
      end
      if (edge_cnt == c_use - P_ONE)
        s0 <= rx_in;
      if (edge_cnt == c_use)
        s1 <= rx_in;
      if (edge_cnt == c_use + P_ONE) begin
        sampled_bit <= maj;
        bit_valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Scoreboard bench for uart_rx_frame_timer against an arithmetic
// model indexed by the number of enabled edges in the current run.
module tb_uart_rx_frame_timer;

  localparam int PW = 6;
  localparam int BW = 4;

  typedef struct {
    logic [PW-1:0] ec;
    logic [BW-1:0] bc;
    logic          bv;
    logic          sb;
    logic          bd;
    logic          fd;
    logic          act;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cnt_en = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic [BW-1:0] frame_len = '0;
  logic          rx_in = 1'b0;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          bit_valid;
  logic          sampled_bit;
  logic          bit_done;
  logic          frame_done;
  logic          active;

  uart_rx_frame_timer #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .clk(clk), .rst(rst), .cnt_en(cnt_en),
    .prescale(prescale), .frame_len(frame_len), .rx_in(rx_in),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .bit_valid(bit_valid),
    .sampled_bit(sampled_bit), .bit_done(bit_done),
    .frame_done(frame_done), .active(active)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   errors  = 0;
  exp_t exp_q[$];

  bit running = 1'b0;
  int n  = 0;
  int mp = 4;
  int ml = 2;
  bit r_q[$];

  function automatic int cur_pos();
    return running ? (n % mp) : 0;
  endfunction

  function automatic int cur_bit();
    return running ? ((n / mp) % ml) : 0;
  endfunction

  task automatic step(input bit en, input int pre, input int len,
                      input bit rx);
    exp_t e;
    int   c;
    @(posedge clk);
    #3;
    cnt_en    = en;
    prescale  = pre[PW-1:0];
    frame_len = len[BW-1:0];
    rx_in     = rx;
    e = '{default: 1'b0};
    if (!en) begin
      running = 1'b0;
      n = 0;
      r_q.delete();
    end else begin
      if (!running) begin
        running = 1'b1;
        n  = 0;
        mp = (pre < 4) ? 4 : pre;
        ml = (len < 2) ? 2 : len;
        r_q.delete();
      end
      n++;
      r_q.push_back(rx);
      if (r_q.size() > 3) void'(r_q.pop_front());
      c = mp / 2;
      e.ec  = PW'(n % mp);
      e.bc  = BW'((n / mp) % ml);
      e.bd  = (n % mp) == 0;
      e.fd  = (n % (mp * ml)) == 0;
      e.bv  = ((n - 1) % mp) == c + 1;
      e.act = 1'b1;
      if (e.bv)
        e.sb = (int'(r_q[0]) + int'(r_q[1]) + int'(r_q[2])) >= 2;
    end
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    vectors++;
    if ({edge_cnt, bit_cnt, bit_valid, sampled_bit, bit_done,
         frame_done, active} !== '0) begin
      errors++;
      $display("FAIL async_reset t=%0t ec=%0d bc=%0d bv=%b sb=%b bd=%b fd=%b act=%b want all 0",
               $time, edge_cnt, bit_cnt, bit_valid, sampled_bit,
               bit_done, frame_done, active);
    end
    cnt_en  = 1'b0;
    running = 1'b0;
    n = 0;
    r_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({edge_cnt, bit_cnt, bit_valid, bit_done, frame_done, active}
            !== {e.ec, e.bc, e.bv, e.bd, e.fd, e.act}) begin
          errors++;
          $display("FAIL timing t=%0t got ec=%0d bc=%0d bv=%b bd=%b fd=%b act=%b want ec=%0d bc=%0d bv=%b bd=%b fd=%b act=%b",
                   $time, edge_cnt, bit_cnt, bit_valid, bit_done,
                   frame_done, active, e.ec, e.bc, e.bv, e.bd, e.fd, e.act);
        end
        if (e.bv) begin
          vectors++;
          if (sampled_bit !== e.sb) begin
            errors++;
            $display("FAIL sampled_bit t=%0t got %b want %b",
                     $time, sampled_bit, e.sb);
          end
        end
      end
    end
  end

  function automatic bit vote_rx(input int pos, input int b);
    case (b % 4)
      0: return (pos == 7 || pos == 9);
      1: return !(pos == 7 || pos == 8 || pos == 9) || pos == 9;
      2: return pos == 8;
      default: return pos != 8;
    endcase
  endfunction

  initial begin : stim
    int cyc;
    do_reset();
    // basic frame
    repeat (80) step(1'b1, 8, 10, 1'b1);
    repeat (3) step(1'b0, 8, 10, 1'b1);
    // majority vote and glitch rejection
    repeat (16 * 8) step(1'b1, 16, 10, vote_rx(cur_pos(), cur_bit()));
    repeat (2) step(1'b0, 16, 10, 1'b0);
    // config freeze, then next run picks up the new config
    repeat (30) step(1'b1, 8, 10, 1'($urandom));
    repeat (60) step(1'b1, 12, 5, 1'($urandom));
    repeat (2) step(1'b0, 12, 5, 1'b0);
    repeat (65) step(1'b1, 12, 5, 1'($urandom));
    step(1'b0, 12, 5, 1'b0);
    // abort at bit 3 edge 5, and abort on a wrap edge
    repeat (29) step(1'b1, 8, 10, 1'($urandom));
    repeat (3) step(1'b0, 8, 10, 1'b0);
    repeat (7) step(1'b1, 8, 10, 1'($urandom));
    repeat (2) step(1'b0, 8, 10, 1'b0);
    // clamp
    repeat (24) step(1'b1, 2, 1, 1'($urandom));
    step(1'b0, 2, 1, 1'b0);
    // back-to-back frames
    repeat (245) step(1'b1, 8, 10, 1'($urandom));
    step(1'b0, 8, 10, 1'b0);
    // async reset mid-bit
    repeat (13) step(1'b1, 8, 10, 1'($urandom));
    do_reset();
    // random configs with live config churn and rare aborts
    for (int r = 0; r < 20; r++) begin
      int pre0;
      int len0;
      pre0 = $urandom_range(0, 63);
      len0 = $urandom_range(0, 15);
      cyc  = $urandom_range(20, 300);
      step(1'b1, pre0, len0, 1'($urandom));
      for (int i = 0; i < cyc; i++)
        step($urandom_range(0, 99) != 0, $urandom_range(0, 63),
             $urandom_range(0, 15), 1'($urandom));
      step(1'b0, 0, 0, 1'b0);
    end
    repeat (2) step(1'b0, 8, 10, 1'b0);
    @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
